// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: word type, reset PC, NOP encoding and base opcodes.
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
   localparam word_t NOP              = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic [6:0] {
      OpLoad   = 7'h03,
      OpImm    = 7'h13,
      OpAuipc  = 7'h17,
      OpStore  = 7'h23,
      OpReg    = 7'h33,
      OpLui    = 7'h37,
      OpBranch = 7'h63,
      OpJalr   = 7'h67,
      OpJal    = 7'h6f,
      OpSystem = 7'h73
   } opcode_e;

   function automatic word_t word_align(input word_t pc);
      return pc & ~word_t'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry instruction word FIFO with push, pop, flush and occupancy count.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  word_t                      push_data,
   input  logic                       pop,
   input  logic                       flush,
   output word_t                      head_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] count_q;
   word_t         mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= NOP;
         end
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues word fetches, buffers in-order responses for decode,
// and discards responses belonging to requests issued before a redirect.
module ifetch_unit
   import riscv_pkg::*;
#(
   parameter word_t       RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned BW = CW + 2;

   word_t         fetch_pc_q, head_pc_q;
   word_t         redirect_target;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [CW-1:0] occupancy;
   logic [BW-1:0] budget;
   logic          req_fire, resp_stale, resp_live, push, pop;

   assign redirect_target = word_align(redirect_pc);

   // Stale responses still need a slot in time, so they count against the buffer budget.
   assign budget = BW'(outstanding_q) + BW'(drop_cnt_q) + BW'(occupancy);

   assign imem_req_valid = !rst && !redirect_valid && (budget < BW'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;

   assign req_fire   = imem_req_valid & imem_req_ready;
   assign resp_stale = imem_resp_valid & (drop_cnt_q != '0);
   assign resp_live  = imem_resp_valid & (drop_cnt_q == '0);
   assign push       = resp_live & ~redirect_valid;
   assign pop        = instr_valid & instr_ready & ~redirect_valid;

   always_comb begin
      drop_cnt_d    = drop_cnt_q - CW'(resp_stale);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_live);
      if (redirect_valid) begin
         // Every request still in flight becomes stale; a live beat this cycle is already gone.
         drop_cnt_d    = drop_cnt_q - CW'(resp_stale) + outstanding_q - CW'(resp_live);
         outstanding_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         head_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         if (redirect_valid) begin
            fetch_pc_q <= redirect_target;
            head_pc_q  <= redirect_target;
         end else begin
            if (req_fire) begin
               fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (pop) begin
               head_pc_q <= head_pc_q + 32'd4;
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fetch_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (imem_resp_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (instr),
      .count     (occupancy)
   );

   assign instr_valid = (occupancy != '0);
   assign instr_pc    = head_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: queue-based memory and fetch model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_ifetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   always #5 clk = ~clk;

   ifetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int latency = 1;
   bit mem_ready = 1'b1;

   // Memory side: accepted requests awaiting their response beat.
   logic [31:0] pend_addr [$];
   int          pend_epoch[$];
   int          pend_due  [$];
   int          last_due;
   // Decode side: instructions the unit must present, in order.
   logic [31:0] buf_pc  [$];
   logic [31:0] buf_data[$];
   int          epoch;
   logic [31:0] exp_fetch_pc, exp_head_pc;
   logic [31:0] acc_log[$];
   logic [31:0] pop_log[$];

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a ^ 32'hC0DE_0000) + 32'h0000_0013;
   endfunction

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", name, act, exp);
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model.
   task automatic step(input bit rd, input logic [31:0] rpc);
      bit resp, exp_rv, exp_iv, do_pop, acc;
      int due;
      redirect_valid  = rd;
      redirect_pc     = rpc;
      imem_req_ready  = mem_ready;
      resp            = (pend_due.size() > 0) && (pend_due[0] <= cyc);
      imem_resp_valid = resp;
      imem_resp_data  = resp ? memfn(pend_addr[0]) : 32'hBAD0_BAD0;
      #1;
      exp_rv = !rd && ((pend_addr.size() + buf_pc.size()) < DEPTH);
      exp_iv = buf_pc.size() > 0;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, exp_fetch_pc);
      chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
      chk("instr_pc", instr_pc, exp_head_pc);
      if (exp_iv) chk("instr", instr, buf_data[0]);

      acc    = imem_req_valid && mem_ready;
      do_pop = !rd && exp_iv && instr_ready;
      if (do_pop) begin
         pop_log.push_back(buf_pc[0]);
         void'(buf_pc.pop_front());
         void'(buf_data.pop_front());
         exp_head_pc += 32'd4;
      end
      if (resp) begin
         if (pend_epoch[0] == epoch && !rd) begin
            buf_pc.push_back(pend_addr[0]);
            buf_data.push_back(memfn(pend_addr[0]));
         end
         void'(pend_addr.pop_front());
         void'(pend_epoch.pop_front());
         void'(pend_due.pop_front());
      end
      if (rd) begin
         epoch++;
         buf_pc.delete();
         buf_data.delete();
         exp_fetch_pc = rpc & ~32'h3;
         exp_head_pc  = rpc & ~32'h3;
      end
      if (acc) begin
         due = cyc + latency;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_addr.push_back(imem_req_addr);
         pend_epoch.push_back(epoch);
         pend_due.push_back(due);
         acc_log.push_back(imem_req_addr);
         exp_fetch_pc += 32'd4;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      instr_ready     = 1'b0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_instr_pc", instr_pc, RST_PC);
      chk("rst_req_addr", imem_req_addr, RST_PC);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pend_addr.delete();
      pend_epoch.delete();
      pend_due.delete();
      buf_pc.delete();
      buf_data.delete();
      acc_log.delete();
      pop_log.delete();
      epoch        = 0;
      last_due     = -1;
      cyc          = 0;
      exp_fetch_pc = RST_PC;
      exp_head_pc  = RST_PC;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int first_iv, n, np;
      bit found;
      rst = 1'b1;
      @(negedge clk);

      // Streaming from reset, latency 1.
      do_reset();
      latency = 1; mem_ready = 1'b1; instr_ready = 1'b1;
      first_iv = -1;
      for (int i = 0; i < 12; i++) begin
         if (instr_valid && first_iv < 0) first_iv = cyc;
         step(1'b0, '0);
      end
      chk("t1_first_valid_cycle", 32'(first_iv), 32'd2);
      chk("t1_req0", qget(acc_log, 0), 32'h0);
      chk("t1_req1", qget(acc_log, 1), 32'h4);
      chk("t1_req2", qget(acc_log, 2), 32'h8);
      chk("t1_pop0", qget(pop_log, 0), 32'h0);

      // Decode stalled from reset: buffer budget caps requests at DEPTH.
      do_reset();
      instr_ready = 1'b0;
      repeat (10) step(1'b0, '0);
      chk("t2_req_count", 32'(acc_log.size()), 32'd2);
      chk("t2_req_valid_low", 32'(imem_req_valid), 32'd0);
      chk("t2_instr_pc_held", instr_pc, 32'h0);
      chk("t2_instr_held", instr, memfn(32'h0));
      instr_ready = 1'b1;
      repeat (12) step(1'b0, '0);
      chk("t2_pop0", qget(pop_log, 0), 32'h0);
      chk("t2_pop3", qget(pop_log, 3), 32'hC);

      // Memory back-pressure: address held, accepted exactly once.
      mem_ready = 1'b0;
      n = acc_log.size();
      repeat (3) step(1'b0, '0);
      chk("t3_no_accept", 32'(acc_log.size()), 32'(n));
      mem_ready = 1'b1;
      step(1'b0, '0);
      chk("t3_accept_once", 32'(acc_log.size()), 32'(n + 1));

      // Latency 3, redirect with two requests in flight.
      do_reset();
      latency = 3; instr_ready = 1'b1;
      repeat (2) step(1'b0, '0);
      chk("t4_req_valid_full", 32'(imem_req_valid), 32'd0);
      step(1'b1, 32'h0000_0103);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (instr_valid) found = 1'b1;
         else step(1'b0, '0);
      end
      chk("t4_valid_seen", 32'(found), 32'd1);
      chk("t4_first_pc", instr_pc, 32'h100);
      chk("t4_first_instr", instr, memfn(32'h100));
      chk("t4_req_after_redirect", qget(acc_log, 2), 32'h100);

      // Redirect coincident with pop and live response.
      do_reset();
      latency = 1; instr_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (buf_pc.size() > 0 && pend_due.size() > 0 && pend_due[0] <= cyc) found = 1'b1;
         else step(1'b0, '0);
      end
      chk("t5_window_found", 32'(found), 32'd1);
      chk("t5_valid_before", 32'(instr_valid), 32'd1);
      np = pop_log.size();
      step(1'b1, 32'h0000_0200);
      chk("t5_valid_after", 32'(instr_valid), 32'd0);
      chk("t5_pc_after", instr_pc, 32'h200);
      repeat (6) step(1'b0, '0);
      chk("t5_next_pop", qget(pop_log, np), 32'h200);

      // Back-to-back redirects, last one wins; wrap at the top of the address space.
      step(1'b1, 32'h0000_0300);
      step(1'b1, 32'hFFFF_FFFE);
      n  = acc_log.size();
      np = pop_log.size();
      repeat (10) step(1'b0, '0);
      chk("t6_req_wrap0", qget(acc_log, n), 32'hFFFF_FFFC);
      chk("t6_req_wrap1", qget(acc_log, n + 1), 32'h0000_0000);
      chk("t6_pop_wrap0", qget(pop_log, np), 32'hFFFF_FFFC);
      chk("t6_pop_wrap1", qget(pop_log, np + 1), 32'h0000_0000);

      // Reset in the middle of traffic.
      latency = 3;
      repeat (4) step(1'b0, '0);
      do_reset();
      latency = 1; instr_ready = 1'b1;
      repeat (8) step(1'b0, '0);
      chk("t7_pop0", qget(pop_log, 0), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
